// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-back, write-allocate cache with true-LRU replacement in front of
// an external word-addressed memory. Define CACHE_FLUSH_EN to add the flush/flush_done whole-cache flush.
module set_assoc_cache #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 2,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_hit,
  output logic                  mem_valid,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           req_count,
  output logic [31:0]           wb_count
`ifdef CACHE_FLUSH_EN
  ,
  input  logic                  flush,
  output logic                  flush_done
`endif
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);
  localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(NUM_WAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND, S_FLUSH
  } state_t;

  state_t                  state_q;
  logic                    wr_q;
  logic [TAG_W-1:0]        rtag_q;
  logic [OFF_W-1:0]        roff_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [IDX_W-1:0]        set_q;
  logic [WAY_W-1:0]        way_q;
  logic [OFF_W-1:0]        beat_q;
  logic [NUM_WAYS-1:0]     valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]     dirty_q [NUM_SETS];
  logic [WAY_W-1:0]        age_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]        tag_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0]   data_q  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  logic                    resp_valid_q, resp_hit_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;
  logic                    mem_valid_q, mem_write_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [31:0]             hit_count_q, miss_count_q, req_count_q, wb_count_q;
`ifdef CACHE_FLUSH_EN
  logic                    flushing_q, flush_done_q;
`endif

  logic                    hit_any, victim_found, last_beat;
  logic [WAY_W-1:0]        hit_way, victim_way, acc_way;
  logic                    fill_we, fill_done, acc_we, touch;
  logic [DATA_WIDTH-1:0]   fill_word, wb_next;

  // Tag compare and victim choice for the latched set
  always_comb begin
    hit_any      = 1'b0;
    hit_way      = '0;
    victim_found = 1'b0;
    victim_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[set_q][w] && (tag_q[set_q][w] == rtag_q)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!victim_found && !valid_q[set_q][w]) begin
        victim_found = 1'b1;
        victim_way   = WAY_W'(w);
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[set_q][w] == LAST_WAY) victim_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    last_beat = (beat_q == LAST_BEAT);
    fill_we   = (state_q == S_REFILL) && mem_valid_q && mem_ready;
    fill_done = fill_we && last_beat;
    touch     = ((state_q == S_LOOKUP) && hit_any) || fill_done;
    acc_way   = (state_q == S_LOOKUP) ? hit_way : way_q;
    acc_we    = wr_q && touch;
    // The requested word may be the one arriving on this final beat
    fill_word = (roff_q == beat_q) ? mem_rdata : data_q[set_q][way_q][roff_q];
    wb_next   = data_q[set_q][way_q][beat_q + OFF_W'(1)];
  end

  // Line storage is not reset; the write-data store follows the refill so it wins on overlap
  always_ff @(posedge clk) begin
    if (fill_we)   data_q[set_q][way_q][beat_q] <= mem_rdata;
    if (acc_we)    data_q[set_q][acc_way][roff_q] <= wdata_q;
    if (fill_done) tag_q[set_q][way_q] <= rtag_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      rtag_q       <= '0;
      roff_q       <= '0;
      wdata_q      <= '0;
      set_q        <= '0;
      way_q        <= '0;
      beat_q       <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      req_count_q  <= '0;
      wb_count_q   <= '0;
`ifdef CACHE_FLUSH_EN
      flushing_q   <= 1'b0;
      flush_done_q <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
`ifdef CACHE_FLUSH_EN
      flush_done_q <= 1'b0;
`endif
      if ((NUM_WAYS > 1) && touch) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == acc_way) age_q[set_q][w] <= '0;
          else if (age_q[set_q][w] < age_q[set_q][acc_way]) age_q[set_q][w] <= age_q[set_q][w] + WAY_W'(1);
        end
      end
      case (state_q)
        S_IDLE: begin
`ifdef CACHE_FLUSH_EN
          if (flush) begin
            flushing_q <= 1'b1;
            set_q      <= '0;
            way_q      <= '0;
            state_q    <= S_FLUSH;
          end else
`endif
          if (req_valid) begin
            wr_q        <= req_write;
            rtag_q      <= req_addr[ADDR_WIDTH-1 -: TAG_W];
            set_q       <= req_addr[OFF_W +: IDX_W];
            roff_q      <= req_addr[OFF_W-1:0];
            wdata_q     <= req_wdata;
            req_count_q <= req_count_q + 32'd1;
            state_q     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit_any) begin
            hit_count_q  <= hit_count_q + 32'd1;
            resp_hit_q   <= 1'b1;
            resp_rdata_q <= wr_q ? wdata_q : data_q[set_q][hit_way][roff_q];
            resp_valid_q <= 1'b1;
            if (wr_q) dirty_q[set_q][hit_way] <= 1'b1;
            state_q      <= S_RESPOND;
          end else begin
            miss_count_q <= miss_count_q + 32'd1;
            way_q        <= victim_way;
            beat_q       <= '0;
            mem_valid_q  <= 1'b1;
            if (valid_q[set_q][victim_way] && dirty_q[set_q][victim_way]) begin
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[set_q][victim_way], set_q, OFF_W'(0)};
              mem_wdata_q <= data_q[set_q][victim_way][0];
              state_q     <= S_WRITEBACK;
            end else begin
              mem_write_q <= 1'b0;
              mem_addr_q  <= {rtag_q, set_q, OFF_W'(0)};
              state_q     <= S_REFILL;
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) begin
            if (!last_beat) begin
              beat_q      <= beat_q + OFF_W'(1);
              mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(1);
              mem_wdata_q <= wb_next;
            end else begin
              wb_count_q  <= wb_count_q + 32'd1;
              beat_q      <= '0;
              mem_write_q <= 1'b0;
`ifdef CACHE_FLUSH_EN
              if (flushing_q) begin
                mem_valid_q             <= 1'b0;
                dirty_q[set_q][way_q]   <= 1'b0;
                state_q                 <= S_FLUSH;
              end else
`endif
              begin
                mem_addr_q <= {rtag_q, set_q, OFF_W'(0)};
                state_q    <= S_REFILL;
              end
            end
          end
        end
        S_REFILL: begin
          if (mem_ready) begin
            if (!last_beat) begin
              beat_q     <= beat_q + OFF_W'(1);
              mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
            end else begin
              mem_valid_q           <= 1'b0;
              valid_q[set_q][way_q] <= 1'b1;
              dirty_q[set_q][way_q] <= wr_q;
              resp_hit_q            <= 1'b0;
              resp_rdata_q          <= wr_q ? wdata_q : fill_word;
              resp_valid_q          <= 1'b1;
              state_q               <= S_RESPOND;
            end
          end
        end
        S_RESPOND: state_q <= S_IDLE;
`ifdef CACHE_FLUSH_EN
        // Visit one line per cycle; dirty lines detour through WRITEBACK and come back clean
        S_FLUSH: begin
          if (valid_q[set_q][way_q] && dirty_q[set_q][way_q]) begin
            beat_q      <= '0;
            mem_valid_q <= 1'b1;
            mem_write_q <= 1'b1;
            mem_addr_q  <= {tag_q[set_q][way_q], set_q, OFF_W'(0)};
            mem_wdata_q <= data_q[set_q][way_q][0];
            state_q     <= S_WRITEBACK;
          end else if (way_q != LAST_WAY) begin
            way_q <= way_q + WAY_W'(1);
          end else begin
            way_q <= '0;
            if (set_q != IDX_W'(NUM_SETS - 1)) begin
              set_q <= set_q + IDX_W'(1);
            end else begin
              for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
              end
              flushing_q   <= 1'b0;
              flush_done_q <= 1'b1;
              state_q      <= S_IDLE;
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CACHE_FLUSH_EN
  assign req_ready  = (state_q == S_IDLE) && !flush;
  assign flush_done = flush_done_q;
`else
  assign req_ready  = (state_q == S_IDLE);
`endif
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_hit   = resp_hit_q;
  assign mem_valid  = mem_valid_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign req_count  = req_count_q;
  assign wb_count   = wb_count_q;

endmodule

// File: doc/set_assoc_cache.md
Name: set_assoc_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache with true-LRU replacement.
- Sits between a single requester and an external word-addressed memory; the backing store is no longer embedded.
- Valid/ready handshake on the request side and a per-word handshake on the memory side.
- Hit, miss, request and writeback statistics counters.

Parameters:
ADDR_WIDTH, 16, word address width
DATA_WIDTH, 16, word width
NUM_SETS, 16, number of sets (power of two, >=2)
NUM_WAYS, 2, associativity (power of two, >=1)
BLOCK_WORDS, 4, words per line (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  cache can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address {tag, index, offset}
req_wdata  in  DATA_WIDTH  write data
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_WIDTH  read data, or written word for writes
resp_hit  out  1  request hit (qualified by resp_valid)
mem_valid  out  1  memory beat request
mem_write  out  1  beat is a write
mem_addr  out  ADDR_WIDTH  word address of beat
mem_wdata  out  DATA_WIDTH  writeback data
mem_ready  in  1  beat accepted; for reads, mem_rdata valid in the same cycle
mem_rdata  in  DATA_WIDTH  refill data
hit_count, miss_count, req_count, wb_count  out  32 each  statistics

Behaviour:
- Address split: offset = low log2(BLOCK_WORDS) bits; index = next log2(NUM_SETS) bits; tag = remaining bits.
- Reset (async): FSM to IDLE; all valid and dirty bits cleared; LRU ages set to way number; all outputs and counters 0. Data RAM is not cleared. Reset mid-transaction abandons it and drops mem_valid immediately.
- FSM states:
  - IDLE: req_ready = 1. On req_valid, latch the request, increment req_count, go to LOOKUP.
  - LOOKUP: req_ready = 0. Compare tag in all ways of the set.
    - Hit: perform the access, increment hit_count, go to RESPOND.
    - Miss: increment miss_count. Victim is the lowest-numbered invalid way, else the way with age NUM_WAYS-1. Victim dirty -> WRITEBACK; otherwise -> REFILL.
  - WRITEBACK: BLOCK_WORDS beats at {victim tag, index, 0..BLOCK_WORDS-1}, ascending, with mem_write = 1. A beat advances only on mem_valid && mem_ready. Increment wb_count after the last beat, then go to REFILL.
  - REFILL: BLOCK_WORDS read beats at {tag, index, 0..}, ascending. Each accepted beat writes mem_rdata into the victim line. After the last beat: set valid, clear dirty, write tag, perform the access, go to RESPOND.
  - RESPOND: resp_valid = 1 for exactly one cycle, then go to IDLE.
- Latency:
  - Hit: resp_valid 2 cycles after acceptance; next request accepted on the following cycle.
  - Clean miss: 2 + BLOCK_WORDS cycles plus memory stalls.
  - Dirty miss: 2 + 2*BLOCK_WORDS cycles plus memory stalls.
- Access rules:
  - Read: resp_rdata = line word.
  - Write: line word <= req_wdata, dirty <= 1, resp_rdata = req_wdata.
  - resp_hit = 1 only for a LOOKUP hit.
- LRU update on every completed access: accessed way age <= 0; ways with age below its old age increment. Ages are log2(NUM_WAYS) bits. With NUM_WAYS = 1 the LRU logic is absent.
- Memory side:
  - mem_valid, mem_addr, mem_write and mem_wdata are held stable until mem_ready.
  - mem_ready while mem_valid = 0 is ignored.
  - mem_valid = 0 outside WRITEBACK and REFILL.
- Counters wrap modulo 2^32. Changes to req_valid outside IDLE are ignored (no backpressure on resp).

Optional Feature:
- Macro: CACHE_FLUSH_EN.
- When defined, adds inputs/outputs flush (in, 1) and flush_done (out, 1).
  - flush is sampled only in IDLE, and takes priority over req_valid.
  - Sequence: req_ready = 0; walk sets 0..NUM_SETS-1 and ways 0..NUM_WAYS-1; write back each valid dirty line (wb_count increments per line); clear all valid bits.
  - On completion, flush_done pulses for one cycle and the FSM returns to IDLE. Statistics other than wb_count are unchanged.
- When undefined: no flush/flush_done ports; dirty data leaves only on eviction.

Test Plan:
- Setup for all scenarios: defaults; memory model returns mem_rdata = mem_addr and always asserts mem_ready.
1. Read 0x0042 after reset -> 4 read beats at 0x0040..0x0043; resp_valid with resp_rdata = 0x0042, resp_hit = 0; miss_count = 1, req_count = 1.
2. Then read 0x0041 -> resp_valid exactly 2 cycles after acceptance, resp_rdata = 0x0041, resp_hit = 1, hit_count = 1, no mem_valid.
3. Write 0x0041 = 0xBEEF (hit); read 0x0080 (miss, way 1); read 0x0040 (hit); read 0x00C0 -> evicts the clean 0x0080 line, no write beats, wb_count = 0.
4. Then read 0x0100 -> evicts the dirty 0x0040 line: write beats 0x0040..0x0043 with data 0x0040, 0xBEEF, 0x0042, 0x0043; then refill 0x0100..0x0103; wb_count = 1, resp_rdata = 0x0100.
5. Hold mem_ready = 0 for 5 cycles mid-refill, then assert reset -> mem_valid drops in the same cycle; all counters 0; re-read 0x0042 is a miss.
6. With CACHE_FLUSH_EN: write 0x0005 = 0x1234, then pulse flush -> 4 write beats 0x0004..0x0007 including 0x1234; flush_done pulses; re-read 0x0005 misses and returns 0x0005.
